pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32, PC and address width in bits.
REQ-002 Parameter STEP, default 4, sequential increment added to PC.
REQ-003 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 pc_ready  input  1  instruction memory accepts current pc this cycle.
REQ-009 stall  input  1  hazard stall; blocks sequential advance.
REQ-010 br_taken  input  1  branch resolved taken; redirect to br_target.
REQ-011 br_target  input  WIDTH  branch destination.
REQ-012 jump  input  1  unconditional jump to jump_target.
REQ-013 jump_target  input  WIDTH  jump destination.
REQ-014 call  input  1  qualifies jump as a call (push return address).
REQ-015 ret  input  1  return; redirect to popped address.
REQ-016 halt  input  1  stop fetching.
REQ-017 pc  output  WIDTH  current fetch address.
REQ-018 pc_plus  output  WIDTH  pc + STEP (combinational).
REQ-019 pc_valid  output  1  pc is a valid fetch request.
REQ-020 ras_empty  output  1  return-address stack holds no entries.

Function
REQ-021 The FSM SHALL have states BOOT, RUN, HALT; reset enters BOOT; BOOT->RUN unconditionally on the next edge; RUN->HALT when halt=1; HALT exits only via rst.
REQ-022 pc_valid SHALL be 1 only in RUN.
REQ-023 pc_plus SHALL equal (pc + STEP) mod 2^WIDTH; wrap from all-ones region is silent.
REQ-024 In RUN, next-pc priority SHALL be: br_taken > jump > ret (stack non-empty) > advance > hold.
REQ-025 Redirects (br_taken, jump, ret) SHALL take effect on the next edge regardless of stall or pc_ready.
REQ-026 Advance (pc <= pc_plus) SHALL occur only when pc_ready=1 and stall=0 and no redirect.
REQ-027 Otherwise pc SHALL hold; a held request keeps pc_valid=1 and pc stable until accepted.
REQ-028 halt asserted with a redirect in the same cycle: the redirect SHALL update pc, then state becomes HALT.
REQ-029 In BOOT and HALT all inputs except rst SHALL be ignored; pc holds.
REQ-030 Redirect latency SHALL be exactly one cycle: target visible on pc the cycle after assertion.

Reset
REQ-031 rst=1 SHALL immediately set pc=RESET_VECTOR, pc_valid=0, state=BOOT, stack pointer=0, ras_empty=1, independent of clk.
REQ-032 Reset mid-operation SHALL discard all pending redirects and stack contents.

Configuration
REQ-033 Macro PC_GEN_RAS_EN SHALL compile in the return-address stack.
REQ-034 With PC_GEN_RAS_EN: jump&call pushes pc_plus (when jump is the winning source); ret pops to pc; push when full overwrites the oldest entry (circular, count saturates at RAS_DEPTH); ret on empty stack is ignored and falls through to advance/hold.
REQ-035 With PC_GEN_RAS_EN: br_taken overriding a call or ret SHALL suppress the push or pop.
REQ-036 Without PC_GEN_RAS_EN: no stack storage; call ignored; ret ignored; ras_empty tied to 1.

Verification
REQ-037 rst pulse, release, pc_ready=1 -> pc=0, pc_valid=0 one cycle, then pc 0,4,8,12 on consecutive edges.
REQ-038 pc=0x10, stall=1 with br_taken=1, br_target=0x200 -> next pc=0x200; stall without branch -> pc holds 0x10.
REQ-039 WIDTH=8, pc=0xFC, advance -> pc=0x00, pc_valid stays 1.
REQ-040 RAS_EN: at pc=0x40 jump&call to 0x100, then ret -> pc=0x100 then 0x44, ras_empty 0->1.
REQ-041 RAS_EN, RAS_DEPTH=4: five nested calls then five rets -> returns of calls 5,4,3,2, fifth ret ignored (pc advances), ras_empty=1.
REQ-042 halt=1 in RUN -> pc_valid=0 next cycle, pc frozen; br_taken ignored; async rst mid-cycle -> pc=RESET_VECTOR immediately.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator: BOOT/RUN/HALT FSM, redirect priority, optional return-address stack
// Build macro PC_GEN_RAS_EN compiles in the return-address stack.
module pc_gen #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_ready,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pc_valid,
  output logic             ras_empty
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_d;

  assign pc_plus  = pc + WIDTH'(STEP);
  assign pc_valid = (state_q == RUN);

`ifdef PC_GEN_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    sp;
  logic [PW:0]      count;
  logic             push, pop;

  assign ras_empty = (count == '0);
`else
  logic unused_ras;
  assign unused_ras = call ^ ret;
  assign ras_empty  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
`ifdef PC_GEN_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // halt still lets this cycle's pc update land before freezing
        if (halt) state_d = HALT;
        if (br_taken) begin
          pc_d = br_target;
        end else if (jump) begin
          pc_d = jump_target;
`ifdef PC_GEN_RAS_EN
          push = call;
`endif
        end
`ifdef PC_GEN_RAS_EN
        else if (ret && !ras_empty) begin
          pc_d = ras_mem[sp - 1'b1];
          pop  = 1'b1;
        end
`endif
        else if (pc_ready && !stall) begin
          pc_d = pc_plus;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc      <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
    end
  end

`ifdef PC_GEN_RAS_EN
  // Circular stack: a push when full lands on the oldest slot, count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + 1'b1;
      if (count != (PW+1)'(RAS_DEPTH)) count <= count + 1'b1;
    end else if (pop) begin
      sp    <= sp - 1'b1;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem[sp] <= pc_plus;
  end
`endif

endmodule
